fetch_queue: RTL and testbench

Instruction fetch queue between the fetch stage and the decode stage. Captures {pc, inst} pairs produced by fetch, buffers up to DEPTH entries in order, and presents them to decode under a valid/ready handshake with a derived pc+4. Supports a single-cycle flush for redirects such as branches, jumps and traps, so fetch can run ahead of a stalled decoder.

---
 rtl/fetch_queue.sv | 65 ++++++
 tb/tb_fetch_queue.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, inst} buffer between fetch and decode with flush; `define FETCH_QUEUE_BYPASS_EN for same-cycle empty bypass
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_inst,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_pc4,
    output logic [31:0]            out_inst,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [63:0]   mem_q [DEPTH];
    logic          stored, bypass, push, pop;

    // Handshake, head selection and next pointer/occupancy state
    always_comb begin
        stored    = count_q != '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass    = !stored && in_valid && !flush;
`else
        bypass    = 1'b0;
`endif
        in_ready  = reset && !count_q[AW];
        out_valid = (stored || bypass) && !flush;
        push      = in_valid && in_ready && !flush && !(bypass && out_ready);
        pop       = stored && out_valid && out_ready;
        out_pc    = !out_valid ? 32'h0000_0000 : stored ? mem_q[rd_ptr_q][63:32] : in_pc;
        out_inst  = !out_valid ? 32'h0000_0013 : stored ? mem_q[rd_ptr_q][31:0] : in_inst;
        out_pc4   = out_pc + 32'd4;
        rd_ptr_d  = flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d  = flush ? '0 : wr_ptr_q + AW'(push);
        count_d   = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Pointer and occupancy registers; only these are cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written at the write pointer on push
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_pc, in_inst};
    end

    assign count = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a queue-based reference model
module tb_fetch_queue;
    localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_inst = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_pc4, out_inst;
    logic [2:0]  count;

    int n_checks = 0, n_pass = 0;
    logic [63:0] q[$];
    logic        e_valid, e_ready;
    logic [31:0] e_pc, e_pc4, e_inst;
    logic [2:0]  e_count;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_pc4(out_pc4), .out_inst(out_inst),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    function automatic void expect_now();
        e_valid = !flush && (q.size() != 0 || (BYP && in_valid));
        e_pc    = !e_valid ? 32'h0 : q.size() != 0 ? q[0][63:32] : in_pc;
        e_inst  = !e_valid ? 32'h13 : q.size() != 0 ? q[0][31:0] : in_inst;
        e_pc4   = e_pc + 32'd4;
        e_ready = reset && q.size() < DEPTH;
        e_count = 3'(q.size());
    endfunction

    task automatic tick();
        bit p, w;
        expect_now();
        p = e_valid && out_ready;
        w = in_valid && e_ready;
        @(posedge clk);
        if (flush || !reset) q.delete();
        else if (!(BYP && q.size() == 0 && p)) begin
            if (p) void'(q.pop_front());
            if (w) q.push_back({in_pc, in_inst});
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({count, out_valid, in_ready, out_pc, out_pc4, out_inst} !== {3'd0, 1'b0, 1'b0, 32'h0, 32'h4, 32'h13})
            $display("FAIL reset_state: got cnt=%0d v=%b rdy=%b pc=%h pc4=%h inst=%h", count, out_valid, in_ready, out_pc, out_pc4, out_inst);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL reset_release: got rdy=%b v=%b cnt=%0d want 1 0 0", in_ready, out_valid, count);
        else n_pass++;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'h0050_0093; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== BYP) $display("FAIL single_same_cycle: out_valid=%b want %b", out_valid, BYP);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_pc, out_pc4, out_inst, count} !== (BYP ? {1'b0, 32'h0, 32'h4, 32'h13, 3'd0} : {1'b1, 32'h0, 32'h4, 32'h0050_0093, 3'd1}))
            $display("FAIL single_next_cycle: got v=%b pc=%h pc4=%h inst=%h cnt=%0d", out_valid, out_pc, out_pc4, out_inst, count);
        else n_pass++;
        tick();
        n_checks++;
        if (count !== 3'd0) $display("FAIL single_drained: count=%0d want 0", count);
        else n_pass++;
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_pc = 32'(4 * i); in_inst = $urandom;
            #1;
            n_checks++;
            if (in_ready !== (i < 4)) $display("FAIL fill_in_ready[%0d]: got %b want %b", i, in_ready, i < 4);
            else n_pass++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({count, in_ready} !== {3'd4, 1'b0}) $display("FAIL fill_full: cnt=%0d rdy=%b want 4 0", count, in_ready);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({out_valid, out_pc} !== {1'b1, 32'(4 * i)}) $display("FAIL fill_order[%0d]: v=%b pc=%h want 1 %h", i, out_valid, out_pc, 4 * i);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({count, out_valid} !== {3'd0, 1'b0}) $display("FAIL fill_empty: cnt=%0d v=%b want 0 0", count, out_valid);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] nx = 32'h1000;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_pc = 32'h1000 + 32'(4 * i); in_inst = $urandom;
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 18; i++) begin
            in_pc = 32'h1000 + 32'(4 * i); in_inst = $urandom;
            #1;
            n_checks++;
            if ({out_valid, out_pc, count} !== {1'b1, nx, 3'd2}) $display("FAIL stream[%0d]: v=%b pc=%h cnt=%0d want 1 %h 2", i, out_valid, out_pc, count, nx);
            else n_pass++;
            nx += 32'd4;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if ({count, out_valid} !== {3'd0, 1'b0}) $display("FAIL stream_drain: cnt=%0d v=%b want 0 0", count, out_valid);
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 32'h2000 + 32'(4 * i); in_inst = $urandom;
            tick();
        end
        flush = 1'b1; out_ready = 1'b1; in_pc = 32'h3000;
        #1;
        n_checks++;
        if ({count, out_valid, out_inst} !== {3'd3, 1'b0, 32'h13}) $display("FAIL flush_cycle: cnt=%0d v=%b inst=%h want 3 0 00000013", count, out_valid, out_inst);
        else n_pass++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++;
        if ({count, out_valid, out_inst} !== {3'd0, 1'b0, 32'h13}) $display("FAIL flush_after: cnt=%0d v=%b inst=%h want 0 0 00000013", count, out_valid, out_inst);
        else n_pass++;
    endtask

    task automatic test_pc4_wrap();
        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'hFFFF_FFFC; in_inst = 32'h0000_006F;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++;
        if ({out_pc, out_pc4} !== {32'hFFFF_FFFC, 32'h0}) $display("FAIL pc4_wrap: pc=%h pc4=%h want fffffffc 00000000", out_pc, out_pc4);
        else n_pass++;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_pc = 32'h4000 + 32'(4 * i); in_inst = $urandom;
            tick();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        q.delete();
        n_checks++;
        if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b0}) $display("FAIL async_reset: cnt=%0d v=%b rdy=%b want 0 0 0", count, out_valid, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) $display("FAIL async_release: cnt=%0d v=%b rdy=%b want 0 0 1", count, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(15) == 0);
            in_valid = $urandom_range(1);
            out_ready = $urandom_range(1);
            in_pc = {$urandom_range(32'h3FFF_FFFF), 2'b00};
            in_inst = $urandom;
            #1;
            expect_now();
            n_checks++;
            if ({out_valid, out_pc, out_pc4, out_inst, in_ready, count} !== {e_valid, e_pc, e_pc4, e_inst, e_ready, e_count})
                $display("FAIL random[%0d]: got v=%b pc=%h pc4=%h inst=%h rdy=%b cnt=%0d want v=%b pc=%h pc4=%h inst=%h rdy=%b cnt=%0d",
                         i, out_valid, out_pc, out_pc4, out_inst, in_ready, count, e_valid, e_pc, e_pc4, e_inst, e_ready, e_count);
            else n_pass++;
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_flush();
        test_pc4_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
